// File: rtl/data_bus_master.sv
// data_bus_master
//   Load/store unit that sits between the single-cycle core datapath and the
//   APB-style data bus (data RAM and peripherals). It accepts one load or store
//   from the core, runs a SETUP/ACCESS bus transfer, and stalls the core with
//   busy until the transfer finishes. Completed loads return the selected byte,
//   half or word, sign- or zero-extended, on rdata.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   req, we, func3    core request, store select, RV32I funct3
//   addr, wdata       byte address (ALU result) and right-aligned store data
//   rdata             extended load data, held until the next good load
//   busy              core stall; done/err one-cycle completion pulse
//   paddr, psel, penable, pwrite, pwdata, pstrb   APB request side
//   prdata, pready, pslverr                       APB response side
module data_bus_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state;
  logic [2:0]  op_func3;
  logic [1:0]  op_off;
  logic [31:0] wait_cnt;

  logic        bad_req;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  // Request decode: legality, alignment and store lane placement, evaluated
  // straight from the core inputs so IDLE can decide in a single cycle.
  always_comb begin
    bad_req = 1'b0;
    st_strb = 4'b0000;
    st_data = 32'h0;
    if (we) begin
      case (func3)
        3'b000: begin
          st_strb = 4'b0001 << addr[1:0];
          st_data = {4{wdata[7:0]}};
        end
        3'b001: begin
          bad_req = addr[0];
          st_strb = addr[1] ? 4'b1100 : 4'b0011;
          st_data = {2{wdata[15:0]}};
        end
        3'b010: begin
          bad_req = (addr[1:0] != 2'b00);
          st_strb = 4'b1111;
          st_data = wdata;
        end
        default: bad_req = 1'b1;
      endcase
    end else begin
      case (func3)
        3'b000, 3'b100: bad_req = 1'b0;
        3'b001, 3'b101: bad_req = addr[0];
        3'b010:         bad_req = (addr[1:0] != 2'b00);
        default:        bad_req = 1'b1;
      endcase
    end
  end

  // Load extraction uses the offset and funct3 latched at request time, since
  // the core's addr is not guaranteed stable once the transfer is under way.
  always_comb begin
    lane_b    = prdata[{op_off, 3'b000} +: 8];
    lane_h    = op_off[1] ? prdata[31:16] : prdata[15:0];
    load_data = prdata;
    case (op_func3)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'h0, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'h0, lane_h};
      default: load_data = prdata;
    endcase
  end

  // A request is reported busy in the same cycle it is raised so the core
  // stalls before the FSM has even left IDLE.
  assign busy = !reset && ((state != IDLE) || req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_func3 <= 3'b000;
      op_off   <= 2'b00;
      wait_cnt <= 32'h0;
      rdata    <= 32'h0;
      done     <= 1'b0;
      err      <= 1'b0;
      paddr    <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      pwdata   <= 32'h0;
      pstrb    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req) begin
            if (bad_req) begin
              // Rejected requests never touch the bus.
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state    <= SETUP;
              op_func3 <= func3;
              op_off   <= addr[1:0];
              paddr    <= {addr[ADDR_W-1:2], 2'b00};
              pwrite   <= we;
              pwdata   <= we ? st_data : 32'h0;
              pstrb    <= we ? st_strb : 4'b0000;
              psel     <= 1'b1;
            end
          end
        end
        SETUP: begin
          state    <= ACCESS;
          penable  <= 1'b1;
          wait_cnt <= 32'h0;
        end
        ACCESS: begin
          if (pready) begin
            state   <= RESP;
            psel    <= 1'b0;
            penable <= 1'b0;
            done    <= 1'b1;
            err     <= pslverr;
            if (!pwrite && !pslverr) begin
              rdata <= load_data;
            end
          end else if ((TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1))) begin
            state   <= RESP;
            psel    <= 1'b0;
            penable <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'h1;
          end
        end
        RESP: begin
          // Any req seen here is the one just completed; it is not re-accepted.
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_master.sv
// tb_data_bus_master
//   Directed-vector bench for data_bus_master: loads of every width, store lane
//   placement, rejected requests, wait states, slave error, timeout and an
//   asynchronous reset in the middle of a transfer.
module tb_data_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] s_paddr, s_pwdata, h_paddr, h_pwdata;
  logic [3:0]  s_pstrb, h_pstrb;
  logic        s_pwrite;
  int          lat;
  logic        saw_psel;

  data_bus_master #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .func3(func3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    req   = r;
    we    = w;
    func3 = f3;
    addr  = a;
    wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raises req and plays the slave: pready goes high after nwait ACCESS
  // cycles. Returns with the bench sitting in the done cycle; lat counts
  // cycles from the request cycle to done.
  task automatic runOp(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int nwait,
                       input logic slverr, output int lat_o, output logic saw_o);
    int waits;
    waits   = 0;
    lat_o   = 0;
    saw_o   = 1'b0;
    prdata  = rd;
    pslverr = slverr;
    pready  = 1'b0;
    applyStimulus(1'b1, w, f3, a, wd);
    while (!done && lat_o < 40) begin
      step();
      lat_o++;
      pready = 1'b0;
      if (psel) saw_o = 1'b1;
      if (psel && !penable) begin
        s_paddr = paddr; s_pwdata = pwdata; s_pstrb = pstrb; s_pwrite = pwrite;
      end
      if (psel && penable) begin
        h_paddr = paddr; h_pwdata = pwdata; h_pstrb = pstrb;
        if (waits >= nwait) pready = 1'b1;
        else waits++;
      end
    end
    pready = 1'b0;
    if (!done) checkOutput("done within bound", {31'h0, done}, 32'h1);
  endtask

  task automatic finishOp();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    reset   = 1'b1;
    prdata  = 32'h0;
    pready  = 1'b0;
    pslverr = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset psel", {31'h0, psel}, 32'h0);
    checkOutput("reset penable", {31'h0, penable}, 32'h0);
    checkOutput("reset done", {31'h0, done}, 32'h0);
    checkOutput("reset busy", {31'h0, busy}, 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset pstrb", {28'h0, pstrb}, 32'h0);
    reset = 1'b0;
    step();

    // LW cycle by cycle against a zero-wait slave
    prdata = 32'hDEADBEEF;
    pready = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1;
    checkOutput("lw busy k", {31'h0, busy}, 32'h1);
    checkOutput("lw psel k", {31'h0, psel}, 32'h0);
    step();
    checkOutput("lw psel k+1", {31'h0, psel}, 32'h1);
    checkOutput("lw penable k+1", {31'h0, penable}, 32'h0);
    checkOutput("lw paddr", paddr, 32'h100);
    step();
    checkOutput("lw penable k+2", {31'h0, penable}, 32'h1);
    checkOutput("lw done k+2", {31'h0, done}, 32'h0);
    step();
    checkOutput("lw done k+3", {31'h0, done}, 32'h1);
    checkOutput("lw err", {31'h0, err}, 32'h0);
    checkOutput("lw rdata", rdata, 32'hDEADBEEF);
    checkOutput("lw psel k+3", {31'h0, psel}, 32'h0);
    pready = 1'b0;
    finishOp();
    checkOutput("lw done clears", {31'h0, done}, 32'h0);
    checkOutput("lw busy clears", {31'h0, busy}, 32'h0);

    // Byte and half loads
    runOp(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b0, lat, saw_psel);
    checkOutput("lb latency", lat, 3);
    checkOutput("lb rdata", rdata, 32'hFFFFFF80);
    finishOp();
    runOp(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b0, lat, saw_psel);
    checkOutput("lbu rdata", rdata, 32'h00000080);
    finishOp();
    runOp(1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 1'b0, lat, saw_psel);
    checkOutput("lh rdata", rdata, 32'hFFFF8001);
    finishOp();
    runOp(1'b0, 3'b101, 32'h100, 32'h0, 32'h80011234, 0, 1'b0, lat, saw_psel);
    checkOutput("lhu rdata", rdata, 32'h00001234);
    checkOutput("lhu pstrb", {28'h0, s_pstrb}, 32'h0);
    finishOp();

    // Stores: lane replication, strobes, stability across SETUP/ACCESS
    runOp(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2, 1'b0, lat, saw_psel);
    checkOutput("sh latency", lat, 5);
    checkOutput("sh paddr", s_paddr, 32'h200);
    checkOutput("sh pwdata", s_pwdata, 32'hABCDABCD);
    checkOutput("sh pstrb", {28'h0, s_pstrb}, 32'hC);
    checkOutput("sh pwrite", {31'h0, s_pwrite}, 32'h1);
    checkOutput("sh paddr stable", h_paddr, 32'h200);
    checkOutput("sh pwdata stable", h_pwdata, 32'hABCDABCD);
    checkOutput("sh pstrb stable", {28'h0, h_pstrb}, 32'hC);
    checkOutput("sh err", {31'h0, err}, 32'h0);
    checkOutput("sh rdata kept", rdata, 32'h00001234);
    finishOp();
    runOp(1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 0, 1'b0, lat, saw_psel);
    checkOutput("sb pwdata", s_pwdata, 32'hA5A5A5A5);
    checkOutput("sb pstrb", {28'h0, s_pstrb}, 32'h2);
    finishOp();
    runOp(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 0, 1'b0, lat, saw_psel);
    checkOutput("sw pwdata", s_pwdata, 32'hCAFEF00D);
    checkOutput("sw pstrb", {28'h0, s_pstrb}, 32'hF);
    finishOp();

    // Rejected requests: done+err next cycle, no bus activity
    runOp(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b0, lat, saw_psel);
    checkOutput("lw misaligned latency", lat, 1);
    checkOutput("lw misaligned err", {31'h0, err}, 32'h1);
    checkOutput("lw misaligned psel", {31'h0, saw_psel}, 32'h0);
    finishOp();
    runOp(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1'b0, lat, saw_psel);
    checkOutput("store f3=100 err", {31'h0, err}, 32'h1);
    checkOutput("store f3=100 psel", {31'h0, saw_psel}, 32'h0);
    finishOp();
    runOp(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0, lat, saw_psel);
    checkOutput("load f3=011 err", {31'h0, err}, 32'h1);
    checkOutput("load f3=011 latency", lat, 1);
    finishOp();
    runOp(1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0, 1'b0, lat, saw_psel);
    checkOutput("sh misaligned err", {31'h0, err}, 32'h1);
    finishOp();

    // Timeout: 16 ACCESS cycles without pready
    runOp(1'b0, 3'b010, 32'h500, 32'h0, 32'h55555555, 99, 1'b0, lat, saw_psel);
    checkOutput("timeout latency", lat, 18);
    checkOutput("timeout err", {31'h0, err}, 32'h1);
    checkOutput("timeout psel", {31'h0, psel}, 32'h0);
    checkOutput("timeout penable", {31'h0, penable}, 32'h0);
    checkOutput("timeout rdata kept", rdata, 32'h00001234);
    finishOp();

    // Slave error after 3 waits; a req held into RESP must not restart
    runOp(1'b0, 3'b010, 32'h600, 32'h0, 32'h11111111, 3, 1'b1, lat, saw_psel);
    checkOutput("slverr latency", lat, 6);
    checkOutput("slverr err", {31'h0, err}, 32'h1);
    checkOutput("slverr rdata kept", rdata, 32'h00001234);
    pslverr = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h800, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("resp req ignored psel", {31'h0, psel}, 32'h0);
    checkOutput("resp req ignored busy", {31'h0, busy}, 32'h0);
    checkOutput("resp req ignored done", {31'h0, done}, 32'h0);
    step();

    // Asynchronous reset in the middle of ACCESS
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
    step();
    step();
    checkOutput("pre-reset penable", {31'h0, penable}, 32'h1);
    #2;
    reset = 1'b1;
    req   = 1'b0;
    #1;
    checkOutput("async reset psel", {31'h0, psel}, 32'h0);
    checkOutput("async reset penable", {31'h0, penable}, 32'h0);
    checkOutput("async reset done", {31'h0, done}, 32'h0);
    checkOutput("async reset busy", {31'h0, busy}, 32'h0);
    step();
    reset = 1'b0;
    step();
    runOp(1'b0, 3'b010, 32'h700, 32'h0, 32'h0BADF00D, 1, 1'b0, lat, saw_psel);
    checkOutput("post-reset latency", lat, 4);
    checkOutput("post-reset rdata", rdata, 32'h0BADF00D);
    checkOutput("post-reset err", {31'h0, err}, 32'h0);
    finishOp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
